// File: rtl/addr_mem_ir_unit.sv
// -----------------------------------------------------------------------------
// addr_mem_ir_unit
//   Address/fetch datapath of the 8-bit teaching CPU:
//     - address register file (AR, SP, PCpast, PC) with two combinational
//       read ports; port B doubles as the memory address,
//     - MEM_DEPTH x WIDTH RAM with synchronous write and combinational read,
//     - 16-bit instruction register loaded a byte at a time from the RAM.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst            synchronous active-high reset (ARF and IR only)
//   arf_i          ARF load data
//   arf_out_a_sel  ARF port A select (00=AR 01=SP 10=PCpast 11=PC)
//   arf_out_b_sel  ARF port B select, same encoding; drives memory address
//   arf_funsel     ARF op: 00 dec, 01 inc, 10 load, 11 clear
//   arf_r_sel      per-register enables: [3]=AR [2]=SP [1]=PCpast [0]=PC
//   mem_data       memory write data
//   mem_wr         1=write, 0=read
//   mem_cs         chip select, active low
//   ir_funsel      IR op: 00 dec, 01 inc, 10 load byte, 11 clear
//   ir_e           IR enable
//   ir_l_h         IR load half: 0=low byte, 1=high byte
//   arf_out_a      ARF port A
//   arf_out_b      ARF port B (memory address)
//   mem_out        memory read data (0 when not reading)
//   ir_out         IR contents
// -----------------------------------------------------------------------------
module addr_mem_ir_unit #(
  parameter int MEM_DEPTH = 256,
  parameter int WIDTH     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   arf_i,
  input  logic [1:0]         arf_out_a_sel,
  input  logic [1:0]         arf_out_b_sel,
  input  logic [1:0]         arf_funsel,
  input  logic [3:0]         arf_r_sel,
  input  logic [WIDTH-1:0]   mem_data,
  input  logic               mem_wr,
  input  logic               mem_cs,
  input  logic [1:0]         ir_funsel,
  input  logic               ir_e,
  input  logic               ir_l_h,
  output logic [WIDTH-1:0]   arf_out_a,
  output logic [WIDTH-1:0]   arf_out_b,
  output logic [WIDTH-1:0]   mem_out,
  output logic [2*WIDTH-1:0] ir_out
);

  logic [WIDTH-1:0]   ar;
  logic [WIDTH-1:0]   sp;
  logic [WIDTH-1:0]   pc_past;
  logic [WIDTH-1:0]   pc;
  logic [2*WIDTH-1:0] ir;

  // Contents start at zero and are deliberately untouched by rst.
  logic [WIDTH-1:0] mem [MEM_DEPTH] = '{default: '0};

  logic mem_rd;
  logic mem_we;

  function automatic logic [WIDTH-1:0] arf_next(input logic [WIDTH-1:0] cur,
                                                input logic [1:0]       op,
                                                input logic [WIDTH-1:0] din);
    logic [WIDTH-1:0] nxt;
    case (op)
      2'b00:   nxt = cur - 1'b1;
      2'b01:   nxt = cur + 1'b1;
      2'b10:   nxt = din;
      default: nxt = '0;
    endcase
    return nxt;
  endfunction

  function automatic logic [2*WIDTH-1:0] ir_next(input logic [2*WIDTH-1:0] cur,
                                                 input logic [1:0]         op,
                                                 input logic               high,
                                                 input logic [WIDTH-1:0]   byte_in);
    logic [2*WIDTH-1:0] nxt;
    case (op)
      2'b00:   nxt = cur - 1'b1;
      2'b01:   nxt = cur + 1'b1;
      2'b10:   nxt = high ? {byte_in, cur[WIDTH-1:0]} : {cur[2*WIDTH-1:WIDTH], byte_in};
      default: nxt = '0;
    endcase
    return nxt;
  endfunction

  function automatic logic [WIDTH-1:0] arf_pick(input logic [1:0] sel,
                                                input logic [WIDTH-1:0] r_ar,
                                                input logic [WIDTH-1:0] r_sp,
                                                input logic [WIDTH-1:0] r_pcp,
                                                input logic [WIDTH-1:0] r_pc);
    logic [WIDTH-1:0] val;
    case (sel)
      2'b00:   val = r_ar;
      2'b01:   val = r_sp;
      2'b10:   val = r_pcp;
      default: val = r_pc;
    endcase
    return val;
  endfunction

  // Combinational read side: both ARF ports and the memory read all reflect
  // pre-edge state, so an IR load in the same cycle as a PC increment fetches
  // from the old PC.
  always_comb begin
    arf_out_a = arf_pick(arf_out_a_sel, ar, sp, pc_past, pc);
    arf_out_b = arf_pick(arf_out_b_sel, ar, sp, pc_past, pc);
  end

  assign mem_rd  = !mem_cs && !mem_wr;
  assign mem_we  = !mem_cs &&  mem_wr;
  assign mem_out = mem_rd ? mem[arf_out_b] : '0;
  assign ir_out  = ir;

  // Memory write is independent of rst: a write coinciding with reset lands.
  always_ff @(posedge clk) begin
    if (mem_we) mem[arf_out_b] <= mem_data;
  end

  // Register state: all enabled ARF registers share one operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar      <= '0;
      sp      <= '0;
      pc_past <= '0;
      pc      <= '0;
      ir      <= '0;
    end else begin
      if (arf_r_sel[3]) ar      <= arf_next(ar,      arf_funsel, arf_i);
      if (arf_r_sel[2]) sp      <= arf_next(sp,      arf_funsel, arf_i);
      if (arf_r_sel[1]) pc_past <= arf_next(pc_past, arf_funsel, arf_i);
      if (arf_r_sel[0]) pc      <= arf_next(pc,      arf_funsel, arf_i);
      if (ir_e)         ir      <= ir_next(ir, ir_funsel, ir_l_h, mem_out);
    end
  end

endmodule

// File: tb/tb_addr_mem_ir_unit.sv
module tb_addr_mem_ir_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  arf_i;
  logic [1:0]  a_sel, b_sel, arf_funsel, ir_funsel;
  logic [3:0]  r_sel;
  logic [7:0]  mem_data;
  logic        mem_wr, mem_cs, ir_e, ir_l_h;
  logic [7:0]  arf_out_a, arf_out_b, mem_out;
  logic [15:0] ir_out;

  addr_mem_ir_unit #(.MEM_DEPTH(256), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .arf_i(arf_i),
    .arf_out_a_sel(a_sel), .arf_out_b_sel(b_sel),
    .arf_funsel(arf_funsel), .arf_r_sel(r_sel),
    .mem_data(mem_data), .mem_wr(mem_wr), .mem_cs(mem_cs),
    .ir_funsel(ir_funsel), .ir_e(ir_e), .ir_l_h(ir_l_h),
    .arf_out_a(arf_out_a), .arf_out_b(arf_out_b),
    .mem_out(mem_out), .ir_out(ir_out)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference state: m_arf indexed by output-select code (0=AR,1=SP,2=PCpast,3=PC).
  int m_arf [4];
  int m_mem [256];
  int m_ir;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int exp_mo();
    return (!mem_cs && !mem_wr) ? m_mem[m_arf[b_sel]] : 0;
  endfunction

  task automatic model_edge();
    int mo, addr;
    mo   = exp_mo();
    addr = m_arf[b_sel];
    if (!mem_cs && mem_wr) m_mem[addr] = int'(mem_data);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_arf[i] = 0;
      m_ir = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sel[3-i]) begin
          case (arf_funsel)
            2'd0: m_arf[i] = (m_arf[i] + 255) % 256;
            2'd1: m_arf[i] = (m_arf[i] + 1) % 256;
            2'd2: m_arf[i] = int'(arf_i);
            default: m_arf[i] = 0;
          endcase
        end
      end
      if (ir_e) begin
        case (ir_funsel)
          2'd0: m_ir = (m_ir + 65535) % 65536;
          2'd1: m_ir = (m_ir + 1) % 65536;
          2'd2: m_ir = ir_l_h ? ((m_ir % 256) + mo * 256) : ((m_ir / 256) * 256 + mo);
          default: m_ir = 0;
        endcase
      end
    end
  endtask

  // Check the settled outputs against the model, then take one clock edge.
  task automatic cycle(input string tag);
    #1;
    chk({tag, ".a"},   {8'h00, arf_out_a}, 16'(m_arf[a_sel]));
    chk({tag, ".b"},   {8'h00, arf_out_b}, 16'(m_arf[b_sel]));
    chk({tag, ".mo"},  {8'h00, mem_out},   16'(exp_mo()));
    chk({tag, ".ir"},  ir_out,             16'(m_ir));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; r_sel = 4'h0; arf_funsel = 2'd0; arf_i = 8'h00;
    mem_cs = 1'b1; mem_wr = 1'b0; mem_data = 8'h00;
    ir_e = 1'b0; ir_funsel = 2'd0; ir_l_h = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 0;
    for (int i = 0; i < 4; i++) m_arf[i] = 0;
    m_ir = 0;
    idle();
    a_sel = 2'd0; b_sel = 2'd0;

    // Initial reset (register state is unknown before it).
    rst = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
    #1;
    chk("reset_a",  {8'h00, arf_out_a}, 16'h0000);
    chk("reset_b",  {8'h00, arf_out_b}, 16'h0000);
    chk("reset_ir", ir_out, 16'h0000);
    cycle("after_reset");

    // ARF ops on PC
    a_sel = 2'd3; r_sel = 4'b0001; arf_funsel = 2'd2; arf_i = 8'h10;
    cycle("pc_load");
    #1 chk("pc_is_10", {8'h00, arf_out_a}, 16'h0010);
    arf_funsel = 2'd1;
    cycle("pc_inc");
    #1 chk("pc_is_11", {8'h00, arf_out_a}, 16'h0011);
    arf_funsel = 2'd3;
    cycle("pc_clr");
    arf_funsel = 2'd0;
    cycle("pc_dec");
    #1 chk("pc_wrap_ff", {8'h00, arf_out_a}, 16'h00FF);

    // Broadcast load to all registers
    r_sel = 4'b1111; arf_funsel = 2'd2; arf_i = 8'h3C;
    cycle("all_load");
    r_sel = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s); b_sel = 2'(3 - s);
      #1;
      chk("all_3c_a", {8'h00, arf_out_a}, 16'h003C);
      chk("all_3c_b", {8'h00, arf_out_b}, 16'h003C);
    end

    // Memory write / read at AR=0x20
    r_sel = 4'b1000; arf_funsel = 2'd2; arf_i = 8'h20; b_sel = 2'd0;
    cycle("ar_load");
    r_sel = 4'b0000; mem_cs = 1'b0; mem_wr = 1'b1; mem_data = 8'hA5;
    cycle("mem_wr");
    mem_wr = 1'b0;
    #1 chk("mem_rd_a5", {8'h00, mem_out}, 16'h00A5);
    mem_cs = 1'b1;
    #1 chk("mem_cs_off", {8'h00, mem_out}, 16'h0000);

    // Fetch setup: mem[0]=0x12, mem[1]=0x34 written through PC
    a_sel = 2'd3; b_sel = 2'd3;
    r_sel = 4'b0001; arf_funsel = 2'd3; ir_e = 1'b1; ir_funsel = 2'd3;
    cycle("fetch_clr");
    ir_e = 1'b0; arf_funsel = 2'd1; mem_cs = 1'b0; mem_wr = 1'b1; mem_data = 8'h12;
    cycle("fill0");
    mem_data = 8'h34;
    cycle("fill1");
    arf_funsel = 2'd3; mem_cs = 1'b1; mem_wr = 1'b0;
    cycle("pc_zero");
    // Fetch: IR byte load with PC increment in the same cycle
    arf_funsel = 2'd1; mem_cs = 1'b0; mem_wr = 1'b0;
    ir_e = 1'b1; ir_funsel = 2'd2; ir_l_h = 1'b0;
    cycle("fetch_lo");
    ir_l_h = 1'b1;
    cycle("fetch_hi");
    idle();
    #1;
    chk("fetch_ir", ir_out, 16'h3412);
    chk("fetch_pc", {8'h00, arf_out_a}, 16'h0002);

    // IR arithmetic and hold
    ir_e = 1'b1; ir_funsel = 2'd3;
    cycle("ir_clr");
    ir_funsel = 2'd0;
    cycle("ir_dec0");
    #1 chk("ir_ffff", ir_out, 16'hFFFF);
    ir_funsel = 2'd1;
    cycle("ir_inc");
    #1 chk("ir_wrap0", ir_out, 16'h0000);
    ir_funsel = 2'd0;
    cycle("ir_dec");
    #1 chk("ir_wrapff", ir_out, 16'hFFFF);
    ir_e = 1'b0; ir_funsel = 2'd3;
    cycle("ir_hold");
    #1 chk("ir_held", ir_out, 16'hFFFF);

    // Reset alongside ARF load, IR load and a memory write at AR=0x20
    a_sel = 2'd0; b_sel = 2'd0;
    r_sel = 4'b1111; arf_funsel = 2'd2; arf_i = 8'h55;
    ir_e = 1'b1; ir_funsel = 2'd2; ir_l_h = 1'b1;
    mem_cs = 1'b0; mem_wr = 1'b1; mem_data = 8'h77;
    rst = 1'b1;
    cycle("rst_mid");
    idle();
    #1;
    chk("rst_mid_a", {8'h00, arf_out_a}, 16'h0000);
    chk("rst_mid_ir", ir_out, 16'h0000);
    r_sel = 4'b1000; arf_funsel = 2'd2; arf_i = 8'h20;
    cycle("ar_reload");
    r_sel = 4'b0000; mem_cs = 1'b0; mem_wr = 1'b0;
    #1 chk("rst_mem_wr", {8'h00, mem_out}, 16'h0077);
    b_sel = 2'd3;
    #1 chk("rst_mem_kept", {8'h00, mem_out}, 16'h0012);

    // Randomised traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 31) == 0);
      arf_i      = 8'($urandom);
      a_sel      = 2'($urandom);
      b_sel      = 2'($urandom);
      arf_funsel = 2'($urandom);
      r_sel      = 4'($urandom);
      mem_data   = 8'($urandom);
      mem_wr     = 1'($urandom);
      mem_cs     = ($urandom_range(0, 3) == 0);
      ir_funsel  = 2'($urandom);
      ir_e       = 1'($urandom);
      ir_l_h     = 1'($urandom);
      cycle("rand");
    end
    idle();
    cycle("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/addr_mem_ir_unit.md
Name: addr_mem_ir_unit

Overview:
- Address/fetch datapath of the 8-bit teaching CPU, combining three parts:
  - address register file (ARF) with AR, SP, PCpast and PC;
  - 256x8 RAM addressed by ARF output B;
  - 16-bit instruction register (IR) loaded a byte at a time from RAM output.
- Sits between the ALU (which supplies write data and ARF load data) and the control unit (which drives all selects).

Parameters:
- MEM_DEPTH, 256, number of 8-bit memory words (address width fixed at 8).
- WIDTH, 8, register and data width of ARF and memory.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- arf_i  in  8  ARF load data.
- arf_out_a_sel  in  2  ARF output A select.
- arf_out_b_sel  in  2  ARF output B select (drives memory address).
- arf_funsel  in  2  ARF operation.
- arf_r_sel  in  4  ARF per-register enables, one bit per register.
- mem_data  in  8  memory write data.
- mem_wr  in  1  1=write, 0=read.
- mem_cs  in  1  chip select, active low.
- ir_funsel  in  2  IR operation.
- ir_e  in  1  IR enable.
- ir_l_h  in  1  IR load half: 0=low byte, 1=high byte.
- arf_out_a  out  8  ARF output A.
- arf_out_b  out  8  ARF output B, which is also the memory address.
- mem_out  out  8  memory read data.
- ir_out  out  16  IR contents.

Behaviour:
- Reset is synchronous and active-high: on a rising clk with rst=1, AR, SP, PCpast, PC and IR become 0. Reset has priority over every other operation. Memory contents are not affected by reset.
- ARF registers: arf_r_sel[3]=AR, [2]=SP, [1]=PCpast, [0]=PC.
- ARF update: each enabled register is updated at the rising edge per arf_funsel:
  - 00: decrement, wraps 0x00 -> 0xFF.
  - 01: increment, wraps 0xFF -> 0x00.
  - 10: load arf_i.
  - 11: clear to 0.
- ARF boundary cases:
  - Disabled registers hold their value.
  - Several enable bits set: all enabled registers perform the same operation in the same cycle.
- ARF output select (applies to both arf_out_a_sel and arf_out_b_sel): 00=AR, 01=SP, 10=PCpast, 11=PC. Both outputs are combinational from current register state. A and B may select the same register.
- Memory array: 256x8, initialised to all zeros at time 0.
  - Write: at rising clk when mem_cs=0 and mem_wr=1, mem[arf_out_b] <= mem_data.
  - Read: combinational. mem_out = mem[arf_out_b] when mem_cs=0 and mem_wr=0; otherwise mem_out = 0.
- IR: when ir_e=1, at the rising edge:
  - 00: decrement the 16-bit value, wraps 0x0000 -> 0xFFFF.
  - 01: increment, wraps 0xFFFF -> 0x0000.
  - 10: load mem_out into [7:0] if ir_l_h=0, or into [15:8] if ir_l_h=1; the other half holds.
  - 11: clear.
- ir_e=0: IR holds regardless of ir_funsel.
- Same-cycle interactions:
  - ARF update and IR load/memory write in the same cycle: IR and memory use the pre-edge address and mem_out. The new ARF value is visible on the outputs after the edge (one-cycle latency for all registered state).
  - IR load while memory is not reading: loads 0x00.
- ir_out reflects IR state directly; no output latency beyond the register.

Test Plan:
- Reset: any prior state, rst=1 for one edge -> arf_out_a=arf_out_b=0x00, ir_out=0x0000; memory contents preserved.
- ARF ops and select:
  - Load 0x10 into PC (r_sel=0001, funsel=10), out_a_sel=11 -> arf_out_a=0x10.
  - Increment -> 0x11.
  - Clear PC; decrement once -> 0xFF.
  - r_sel=1111 with load 0x3C -> all four outputs read 0x3C.
- Memory write/read:
  - AR=0x20, out_b_sel=00, mem_cs=0, mem_wr=1, mem_data=0xA5, one edge -> then with mem_wr=0, mem_out=0xA5.
  - mem_cs=1 -> mem_out=0x00.
- Fetch sequence:
  - mem[0x00]=0x12, mem[0x01]=0x34, PC=0x00, out_b_sel=11.
  - Cycle 1: IR load low (e=1, funsel=10, l_h=0) with PC increment in the same cycle.
  - Cycle 2: IR load high.
  - Result: ir_out=0x3412, PC=0x02.
- IR arithmetic: IR=0xFFFF, funsel=01 -> 0x0000; funsel=00 -> 0xFFFF; ir_e=0 with funsel=11 -> 0xFFFF held.
- Reset mid-operation: rst=1 asserted in the same cycle as an ARF load and IR load -> all registers 0x00/0x0000; a simultaneous memory write still completes.
